// File: rtl/pwm_duty_ramper.sv
// Duty-cycle slew sequencer for PWMGenerator: ramps duty toward a target by a bounded step per PWM period.
// Optional feature: define PWM_RAMP_RETARGET_EN to accept new targets while a ramp is in progress.
module pwm_duty_ramper #(
    parameter int              WIDTH          = 8,
    parameter logic [WIDTH-1:0] DEFAULT_PERIOD = WIDTH'(128)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             target_valid,
    output logic             target_ready,
    input  logic [WIDTH-1:0] target_period,
    input  logic [WIDTH-1:0] target_duty,
    input  logic [WIDTH-1:0] ramp_step,
    input  logic             period_start,
    output logic             update_parameters,
    output logic [WIDTH-1:0] pwm_period,
    output logic [WIDTH-1:0] pwm_duty_cycle,
    output logic             busy,
    output logic             done
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } state_t;

    state_t           state_r;
    logic             ready_r;
    logic             update_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] period_out_r;
    logic [WIDTH-1:0] cur_r;
    logic [WIDTH-1:0] tgt_period_r;
    logic [WIDTH-1:0] tgt_duty_r;
    logic [WIDTH-1:0] step_r;

    logic             accept_s;
    logic [WIDTH-1:0] eff_period_s;
    logic [WIDTH-1:0] eff_tgt_s;
    logic [WIDTH-1:0] eff_step_s;
    logic [WIDTH-1:0] next_cur_s;

    // A duty request larger than the period would mean "always high"; cap it at the period.
    function automatic logic [WIDTH-1:0] clamp_duty(input logic [WIDTH-1:0] duty,
                                                    input logic [WIDTH-1:0] period);
        logic [WIDTH-1:0] res;
        if (duty > period) begin
            res = period;
        end else begin
            res = duty;
        end
        return res;
    endfunction

    // A zero step would stall the ramp forever, so it is promoted to one.
    function automatic logic [WIDTH-1:0] clamp_step(input logic [WIDTH-1:0] step);
        logic [WIDTH-1:0] res;
        if (step == {WIDTH{1'b0}}) begin
            res = WIDTH'(1);
        end else begin
            res = step;
        end
        return res;
    endfunction

    // One bounded move of cur toward tgt; widened by one bit so neither direction can wrap.
    function automatic logic [WIDTH-1:0] ramp_next(input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] tgt,
                                                   input logic [WIDTH-1:0] step);
        logic [WIDTH:0] cur_w;
        logic [WIDTH:0] tgt_w;
        logic [WIDTH:0] step_w;
        logic [WIDTH:0] res_w;
        cur_w  = {1'b0, cur};
        tgt_w  = {1'b0, tgt};
        step_w = {1'b0, step};
        if (cur_w < tgt_w) begin
            if ((tgt_w - cur_w) <= step_w) begin
                res_w = tgt_w;
            end else begin
                res_w = cur_w + step_w;
            end
        end else if (cur_w > tgt_w) begin
            if ((cur_w - tgt_w) <= step_w) begin
                res_w = tgt_w;
            end else begin
                res_w = cur_w - step_w;
            end
        end else begin
            res_w = tgt_w;
        end
        return res_w[WIDTH-1:0];
    endfunction

    assign accept_s = target_valid & ready_r;

    // Effective target: a same-cycle accept overrides the latched target for the step decision.
    always_comb begin
        eff_period_s = tgt_period_r;
        eff_tgt_s    = tgt_duty_r;
        eff_step_s   = step_r;
        if (accept_s) begin
            eff_period_s = target_period;
            eff_tgt_s    = clamp_duty(target_duty, target_period);
            eff_step_s   = clamp_step(ramp_step);
        end else begin
            eff_period_s = tgt_period_r;
            eff_tgt_s    = tgt_duty_r;
            eff_step_s   = step_r;
        end
        next_cur_s = ramp_next(cur_r, eff_tgt_s, eff_step_s);
    end

    // Sequencer FSM with all downstream outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            ready_r      <= 1'b1;
            update_r     <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            period_out_r <= DEFAULT_PERIOD;
            cur_r        <= {WIDTH{1'b0}};
            tgt_period_r <= DEFAULT_PERIOD;
            tgt_duty_r   <= {WIDTH{1'b0}};
            step_r       <= WIDTH'(1);
        end else begin
            update_r <= 1'b0;
            done_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // period_start is deliberately ignored here, including in the accept cycle.
                    if (accept_s) begin
                        tgt_period_r <= eff_period_s;
                        tgt_duty_r   <= eff_tgt_s;
                        step_r       <= eff_step_s;
                        state_r      <= ST_RAMP;
                        busy_r       <= 1'b1;
`ifdef PWM_RAMP_RETARGET_EN
                        ready_r      <= 1'b1;
`else
                        ready_r      <= 1'b0;
`endif
                    end else begin
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                end
                ST_RAMP: begin
`ifdef PWM_RAMP_RETARGET_EN
                    if (accept_s) begin
                        tgt_period_r <= eff_period_s;
                        tgt_duty_r   <= eff_tgt_s;
                        step_r       <= eff_step_s;
                    end else begin
                        tgt_period_r <= tgt_period_r;
                    end
`endif
                    if (period_start) begin
                        cur_r        <= next_cur_s;
                        period_out_r <= eff_period_s;
                        update_r     <= 1'b1;
                        if (next_cur_s == eff_tgt_s) begin
                            done_r  <= 1'b1;
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                            ready_r <= 1'b1;
                        end else begin
                            busy_r <= 1'b1;
                        end
                    end else begin
                        busy_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign target_ready      = ready_r;
    assign update_parameters = update_r;
    assign pwm_period        = period_out_r;
    assign pwm_duty_cycle    = cur_r;
    assign busy              = busy_r;
    assign done              = done_r;

endmodule

// File: tb/tb_pwm_duty_ramper.sv
// Directed self-checking bench for pwm_duty_ramper (WIDTH=8, DEFAULT_PERIOD=128).
module tb_pwm_duty_ramper;

    logic       clk;
    logic       reset;
    logic       target_valid;
    logic       target_ready;
    logic [7:0] target_period;
    logic [7:0] target_duty;
    logic [7:0] ramp_step;
    logic       period_start;
    logic       update_parameters;
    logic [7:0] pwm_period;
    logic [7:0] pwm_duty_cycle;
    logic       busy;
    logic       done;

    int n_checks;
    int n_fail;
    int upd_cnt;
    int ready_seen;

    pwm_duty_ramper dut (
        .clk               (clk),
        .reset             (reset),
        .target_valid      (target_valid),
        .target_ready      (target_ready),
        .target_period     (target_period),
        .target_duty       (target_duty),
        .ramp_step         (ramp_step),
        .period_start      (period_start),
        .update_parameters (update_parameters),
        .pwm_period        (pwm_period),
        .pwm_duty_cycle    (pwm_duty_cycle),
        .busy              (busy),
        .done              (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks = n_checks + 1;
        if (obs != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Pulse period_start for one cycle; afterwards the resulting update is visible.
    task automatic tick();
        period_start = 1'b1;
        cyc();
        period_start = 1'b0;
    endtask

    task automatic offer(input int per, input int duty, input int step, input bit with_ps);
        target_valid  = 1'b1;
        target_period = 8'(per);
        target_duty   = 8'(duty);
        ramp_step     = 8'(step);
        period_start  = with_ps;
        ready_seen    = int'(target_ready);
        cyc();
        target_valid = 1'b0;
        period_start = 1'b0;
    endtask

    task automatic tick_expect(input string tag, input int duty, input int per, input int dn);
        tick();
        check_val({tag, "_upd"}, int'(update_parameters), 1);
        check_val({tag, "_duty"}, int'(pwm_duty_cycle), duty);
        check_val({tag, "_per"}, int'(pwm_period), per);
        check_val({tag, "_done"}, int'(done), dn);
        cyc();
        check_val({tag, "_upd_off"}, int'(update_parameters), 0);
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        reset = 1'b1;
        target_valid = 1'b0;
        target_period = 8'd0;
        target_duty = 8'd0;
        ramp_step = 8'd0;
        period_start = 1'b0;
        cyc();
        cyc();
        check_val("rst_period", int'(pwm_period), 128);
        check_val("rst_duty", int'(pwm_duty_cycle), 0);
        check_val("rst_ready", int'(target_ready), 1);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_done", int'(done), 0);
        check_val("rst_upd", int'(update_parameters), 0);
        reset = 1'b0;

        // Idle: period_start every 128 cycles must never cause an update.
        upd_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            period_start = ((i % 128) == 0);
            cyc();
            if (update_parameters) upd_cnt = upd_cnt + 1;
        end
        period_start = 1'b0;
        check_val("idle_no_upd", upd_cnt, 0);

        // Ramp up 0 -> 40 in steps of 16.
        offer(100, 40, 16, 1'b0);
        check_val("up_ready_before", ready_seen, 1);
        check_val("up_busy", int'(busy), 1);
        check_val("up_upd0", int'(update_parameters), 0);
        check_val("up_per_held", int'(pwm_period), 128);
`ifndef PWM_RAMP_RETARGET_EN
        check_val("up_ready_ramp", int'(target_ready), 0);
`endif
        cyc();
        tick_expect("up16", 16, 100, 0);
        tick_expect("up32", 32, 100, 0);
        tick_expect("up40", 40, 100, 1);
        check_val("up_busy_after", int'(busy), 0);
        check_val("up_ready_after", int'(target_ready), 1);
        check_val("up_duty_held", int'(pwm_duty_cycle), 40);

        // Ramp down with clamps: tgt=min(200,30)=30, step=max(0,1)=1.
        offer(30, 200, 0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            tick_expect($sformatf("dn%0d", 40 - k), 40 - k, 30, (k == 10) ? 1 : 0);
        end
        offer(30, 0, 255, 1'b0);
        tick_expect("dn_zero", 0, 30, 1);
        check_val("dn_busy_after", int'(busy), 0);

        // Accept coincides with period_start: no step that period.
        offer(100, 20, 255, 1'b1);
        check_val("coin_no_upd", int'(update_parameters), 0);
        check_val("coin_duty", int'(pwm_duty_cycle), 0);
        cyc();
        check_val("coin_no_upd2", int'(update_parameters), 0);
        tick_expect("coin20", 20, 100, 1);

        // Equal target: a single update carrying the new period, plus done.
        offer(90, 20, 5, 1'b0);
        tick_expect("eq20", 20, 90, 1);
        tick();
        check_val("eq_no_more", int'(update_parameters), 0);

        // Reset mid-ramp at duty 32 heading to 64.
        offer(128, 64, 12, 1'b0);
        tick_expect("mr32", 32, 128, 0);
        reset = 1'b1;
        #2;
        check_val("mr_async_duty", int'(pwm_duty_cycle), 0);
        check_val("mr_async_busy", int'(busy), 0);
        check_val("mr_async_ready", int'(target_ready), 1);
        check_val("mr_async_per", int'(pwm_period), 128);
        cyc();
        reset = 1'b0;
        upd_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (update_parameters) upd_cnt = upd_cnt + 1;
        end
        check_val("mr_no_upd", upd_cnt, 0);

        // Retarget attempt while ramping 0 -> 64 (step 16), at duty 32.
        offer(100, 64, 16, 1'b0);
        tick_expect("rt16", 16, 100, 0);
        tick_expect("rt32", 32, 100, 0);
        offer(100, 10, 16, 1'b0);
`ifdef PWM_RAMP_RETARGET_EN
        check_val("rt_ready", ready_seen, 1);
        tick_expect("rt_to16", 16, 100, 0);
        tick_expect("rt_to10", 10, 100, 1);
`else
        check_val("rt_ready", ready_seen, 0);
        check_val("rt_busy", int'(busy), 1);
        tick_expect("rt48", 48, 100, 0);
        tick_expect("rt64", 64, 100, 1);
`endif
        check_val("rt_busy_after", int'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
